// File: rtl/sseg_scan.sv
// Digit-scan driver for a 4-digit multiplexed 7-seg display, one-cold anodes.
// Define SSEG_SCAN_LZB_EN to enable leading-zero blanking of digits 1..3.
module sseg_scan #(
   parameter int DIV   = 25000,
   parameter int BLANK = 250
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] bcd0,
   input  logic [3:0] bcd1,
   input  logic [3:0] bcd2,
   input  logic [3:0] bcd3,
   output logic [3:0] sel,
   output logic [1:0] digit_idx,
   output logic       tick
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] BEND = CW'((BLANK > 0) ? BLANK - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

   localparam state_t START = (BLANK == 0) ? S_DRIVE : S_BLANK;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    sel_q, sel_d;
   logic          tick_q, tick_d;
   logic          dark_q, dark_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         sel_q   <= 4'b1111;
         tick_q  <= 1'b0;
         dark_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         tick_q  <= tick_d;
         dark_q  <= dark_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      if (!en) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = START;
               cnt_d   = '0;
            end
            default: begin
               if (cnt_q == LAST) begin
                  state_d = START;
                  cnt_d   = '0;
                  idx_d   = idx_q + 2'd1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
                  if (state_q == S_BLANK && cnt_q == BEND)
                     state_d = S_DRIVE;
               end
            end
         endcase
      end
   end

   // Outputs are registered from next-state values so they track state_q exactly.
`ifdef SSEG_SCAN_LZB_EN
   logic slot_start;
   wire  unused_bcd0 = &{1'b0, bcd0};

   always_comb begin
      slot_start = en && (state_q == S_IDLE || cnt_q == LAST);
      dark_d     = dark_q;
      if (slot_start) begin
         unique case (idx_d)
            2'd1:    dark_d = ({bcd1, bcd2, bcd3} == 12'd0);
            2'd2:    dark_d = ({bcd2, bcd3} == 8'd0);
            2'd3:    dark_d = (bcd3 == 4'd0);
            default: dark_d = 1'b0;
         endcase
      end
   end
`else
   wire unused_bcd = &{1'b0, bcd0, bcd1, bcd2, bcd3};

   always_comb begin
      dark_d = 1'b0;
   end
`endif

   always_comb begin
      sel_d  = 4'b1111;
      tick_d = (state_d != S_IDLE) && (cnt_d == LAST);
      if (state_d == S_DRIVE && !dark_d)
         sel_d = ~(4'b0001 << idx_d);
   end

   assign sel       = sel_q;
   assign digit_idx = idx_q;
   assign tick      = tick_q;

endmodule

// File: tb/tb_sseg_scan.sv
// Directed table-driven bench for sseg_scan (DIV=8/BLANK=2 and DIV=2/BLANK=0).
// Honours SSEG_SCAN_LZB_EN in its expectations when defined.
module tb_sseg_scan;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       en2 = 1'b0;
   logic [3:0] bcd0 = 4'd7;
   logic [3:0] bcd1 = 4'd4;
   logic [3:0] bcd2 = 4'd0;
   logic [3:0] bcd3 = 4'd0;
   logic [3:0] sel, sel2;
   logic [1:0] idx, idx2;
   logic       tick, tick2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sseg_scan #(.DIV(8), .BLANK(2)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3),
      .sel(sel), .digit_idx(idx), .tick(tick)
   );

   sseg_scan #(.DIV(2), .BLANK(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en2),
      .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3),
      .sel(sel2), .digit_idx(idx2), .tick(tick2)
   );

   typedef struct {
      logic       en;
      int         n;
      logic [3:0] sel;
      logic [1:0] idx;
      logic       tk;
   } seg_t;

   seg_t tbl[24];

   function automatic logic [3:0] dsel(int k);
`ifdef SSEG_SCAN_LZB_EN
      if (k >= 2) return 4'b1111;
`endif
      case (k)
         0:       return 4'b1110;
         1:       return 4'b1101;
         2:       return 4'b1011;
         default: return 4'b0111;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [3:0] act,
                      input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic run_seg(input seg_t s);
      for (int i = 0; i < s.n; i++) begin
         en = s.en;
         @(posedge clk);
         #1;
         chk("sel", sel, s.sel);
         chk("idx", {2'b00, idx}, {2'b00, s.idx});
         chk("tick", {3'b000, tick},
             {3'b000, (s.tk && i == s.n - 1)});
         total++;
         if ($countones(~sel) > 1) begin
            bad++;
            $display("FAIL onecold: got %b want <=1 low", sel);
         end
      end
   endtask

   initial begin
      // test 1/2: rotation through a full frame and wrap
      tbl[0]  = '{1'b1, 2, 4'b1111, 2'd0, 1'b0};
      tbl[1]  = '{1'b1, 6, dsel(0), 2'd0, 1'b1};
      tbl[2]  = '{1'b1, 2, 4'b1111, 2'd1, 1'b0};
      tbl[3]  = '{1'b1, 6, dsel(1), 2'd1, 1'b1};
      tbl[4]  = '{1'b1, 2, 4'b1111, 2'd2, 1'b0};
      tbl[5]  = '{1'b1, 6, dsel(2), 2'd2, 1'b1};
      tbl[6]  = '{1'b1, 2, 4'b1111, 2'd3, 1'b0};
      tbl[7]  = '{1'b1, 6, dsel(3), 2'd3, 1'b1};
      tbl[8]  = '{1'b1, 2, 4'b1111, 2'd0, 1'b0};
      tbl[9]  = '{1'b1, 6, dsel(0), 2'd0, 1'b1};
      // test 3: disable mid-drive of digit 2, resume fresh slot
      tbl[10] = '{1'b1, 2, 4'b1111, 2'd1, 1'b0};
      tbl[11] = '{1'b1, 6, dsel(1), 2'd1, 1'b1};
      tbl[12] = '{1'b1, 2, 4'b1111, 2'd2, 1'b0};
      tbl[13] = '{1'b1, 3, dsel(2), 2'd2, 1'b0};
      tbl[14] = '{1'b0, 3, 4'b1111, 2'd2, 1'b0};
      tbl[15] = '{1'b1, 2, 4'b1111, 2'd2, 1'b0};
      tbl[16] = '{1'b1, 6, dsel(2), 2'd2, 1'b1};
      tbl[17] = '{1'b1, 2, 4'b1111, 2'd3, 1'b0};
      tbl[18] = '{1'b1, 3, dsel(3), 2'd3, 1'b0};
      // after reset: en drop on tick cycle suppresses rotation
      tbl[19] = '{1'b1, 2, 4'b1111, 2'd0, 1'b0};
      tbl[20] = '{1'b1, 6, 4'b1110, 2'd0, 1'b1};
      tbl[21] = '{1'b0, 1, 4'b1111, 2'd0, 1'b0};
      tbl[22] = '{1'b1, 2, 4'b1111, 2'd0, 1'b0};
      tbl[23] = '{1'b1, 6, 4'b1110, 2'd0, 1'b1};

      en = 1'b1;
      #12;
      chk("rst_sel", sel, 4'b1111);
      chk("rst_idx", {2'b00, idx}, 4'd0);
      chk("rst_tick", {3'b000, tick}, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k <= 18; k++) run_seg(tbl[k]);

      // test 4: async reset mid-drive of digit 3, checked before next edge
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_sel", sel, 4'b1111);
      chk("arst_idx", {2'b00, idx}, 4'd0);
      chk("arst_tick", {3'b000, tick}, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 19; k <= 23; k++) run_seg(tbl[k]);

      // test 5: DIV=2, BLANK=0
      en = 1'b0;
      rst_n = 1'b0;
      en2 = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         chk("d2_sel", sel2, dsel(((c - 1) / 2) % 4));
         chk("d2_idx", {2'b00, idx2}, 4'(((c - 1) / 2) % 4));
         chk("d2_tick", {3'b000, tick2}, {3'b000, (c % 2 == 0)});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
